// File: rtl/ir_nec_tx_if.sv
// rtl/ir_nec_tx_if.sv - control and line signals of the NEC infrared transmitter
interface ir_nec_tx_if;
  logic        send;
  logic [31:0] data;
  logic        busy;
  logic        done;
  logic        irda;
  logic        ir_led;

  modport master (
    output send, data,
    input  busy, done, irda, ir_led
  );

  modport slave (
    input  send, data,
    output busy, done, irda, ir_led
  );
endinterface

// File: rtl/ir_nec_tx.sv
// rtl/ir_nec_tx.sv - NEC infrared frame transmitter with demodulated and 38 kHz carrier outputs
module ir_nec_tx #(
  parameter int LEAD_MARK_DUR  = 450000,
  parameter int LEAD_SPACE_DUR = 225000,
  parameter int BIT_MARK_DUR   = 28000,
  parameter int ZERO_SPACE_DUR = 28000,
  parameter int ONE_SPACE_DUR  = 84500,
  parameter int GAP_DUR        = 2000000,
  parameter int CARRIER_HALF   = 658,
  parameter int CNT_W          = 22,
  parameter int CAR_W          = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  ir_nec_tx_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt, len_m1;
  logic [31:0]        sh, sh_nxt;
  logic [5:0]         bitcnt, bitcnt_nxt;
  logic [CAR_W-1:0]   ccnt, ccnt_nxt;
  logic               cphase, cphase_nxt;
  logic               busy_nxt, done_nxt, irda_nxt, led_nxt;
  logic               last, mark_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sh         <= '0;
      bitcnt     <= '0;
      ccnt       <= '0;
      cphase     <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.irda   <= 1'b1;
      bus.ir_led <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sh         <= sh_nxt;
      bitcnt     <= bitcnt_nxt;
      ccnt       <= ccnt_nxt;
      cphase     <= cphase_nxt;
      bus.busy   <= busy_nxt;
      bus.done   <= done_nxt;
      bus.irda   <= irda_nxt;
      bus.ir_led <= led_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + CNT_W'(1);
    sh_nxt     = sh;
    bitcnt_nxt = bitcnt;
    len_m1     = '0;

    case (state)
      LEAD_MARK:            len_m1 = CNT_W'(LEAD_MARK_DUR - 1);
      LEAD_SPACE:           len_m1 = CNT_W'(LEAD_SPACE_DUR - 1);
      BIT_MARK, STOP_MARK:  len_m1 = CNT_W'(BIT_MARK_DUR - 1);
      BIT_SPACE:            len_m1 = sh[0] ? CNT_W'(ONE_SPACE_DUR - 1) : CNT_W'(ZERO_SPACE_DUR - 1);
      GAP:                  len_m1 = CNT_W'(GAP_DUR - 1);
      default:              len_m1 = '0;
    endcase
    last = (cnt == len_m1);

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (bus.send) begin
          state_nxt  = LEAD_MARK;
          sh_nxt     = bus.data;
          bitcnt_nxt = '0;
        end
      end
      LEAD_MARK:  if (last) state_nxt = LEAD_SPACE;
      LEAD_SPACE: if (last) state_nxt = BIT_MARK;
      BIT_MARK:   if (last) state_nxt = BIT_SPACE;
      BIT_SPACE: begin
        if (last) begin
          sh_nxt     = {1'b0, sh[31:1]};
          bitcnt_nxt = bitcnt + 6'd1;
          state_nxt  = (bitcnt != 6'd31) ? BIT_MARK : STOP_MARK;
        end
      end
      STOP_MARK:  if (last) state_nxt = GAP;
      GAP:        if (last) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase

    if (state_nxt != state) cnt_nxt = '0;

    // Outputs are registered from the next-state view so they line up with the state register.
    mark_nxt = (state_nxt == LEAD_MARK) || (state_nxt == BIT_MARK) || (state_nxt == STOP_MARK);
    if (mark_nxt && (state_nxt != state)) begin
      ccnt_nxt   = '0;
      cphase_nxt = 1'b1;
    end else if (ccnt == CAR_W'(CARRIER_HALF - 1)) begin
      ccnt_nxt   = '0;
      cphase_nxt = ~cphase;
    end else begin
      ccnt_nxt   = ccnt + CAR_W'(1);
      cphase_nxt = cphase;
    end

    busy_nxt = (state_nxt != IDLE);
    irda_nxt = ~mark_nxt;
    led_nxt  = mark_nxt & cphase_nxt;
    done_nxt = (state_nxt == GAP) && (cnt_nxt == CNT_W'(GAP_DUR - 1));
  end

endmodule

// File: tb/tb_ir_nec_tx.sv
// tb/tb_ir_nec_tx.sv - scoreboard bench for ir_nec_tx with shortened phase durations
module tb_ir_nec_tx;
  localparam int LM   = 90;
  localparam int LS   = 45;
  localparam int BM   = 6;
  localparam int ZS   = 6;
  localparam int OS   = 17;
  localparam int GD   = 40;
  localparam int HALF = 4;
  // Leader of 90 cycles with a 4-cycle half period: rises at 0, 8, ..., 88.
  localparam int LEADER_RISES = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ir_nec_tx_if bus();

  ir_nec_tx #(
    .LEAD_MARK_DUR(LM), .LEAD_SPACE_DUR(LS), .BIT_MARK_DUR(BM),
    .ZERO_SPACE_DUR(ZS), .ONE_SPACE_DUR(OS), .GAP_DUR(GD),
    .CARRIER_HALF(HALF), .CNT_W(22), .CAR_W(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    bit is_done;
    bit level;
    int len;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input bit d, input bit lvl, input int len);
    exp_t x;
    x.is_done = d;
    x.level   = lvl;
    x.len     = len;
    return x;
  endfunction

  task automatic push_frame(input logic [31:0] d);
    exp_q.push_back(mk(1'b0, 1'b0, LM));
    exp_q.push_back(mk(1'b0, 1'b1, LS));
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(mk(1'b0, 1'b0, BM));
      exp_q.push_back(mk(1'b0, 1'b1, d[i] ? OS : ZS));
    end
    exp_q.push_back(mk(1'b0, 1'b0, BM));
    exp_q.push_back(mk(1'b1, 1'b1, GD));
  endtask

  // Monitor: measures every irda run and the gap length at each done pulse.
  bit idle = 1'b1;
  bit prev_irda = 1'b1;
  bit prev_led = 1'b0;
  bit in_leader = 1'b0;
  bit led_space = 1'b0;
  int run_len = 0;
  int rises = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      idle = 1'b1; prev_irda = 1'b1; prev_led = 1'b0;
      in_leader = 1'b0; led_space = 1'b0; run_len = 0;
    end else begin
      if (bus.irda !== prev_irda) begin
        if (!idle) begin
          if (exp_q.size() == 0) begin
            check("extra_run", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("run_kind", 0, e.is_done);
            check("run_level", prev_irda, e.level);
            check("run_len", run_len, e.len);
            if (prev_irda) check("led_in_space", led_space, 0);
          end
          if (in_leader) begin
            check("leader_rises", rises, LEADER_RISES);
            in_leader = 1'b0;
          end
        end
        if (!bus.irda && idle) begin
          idle = 1'b0; in_leader = 1'b1; rises = 0;
        end
        run_len = 1;
        led_space = 1'b0;
      end else begin
        run_len++;
      end
      if (bus.ir_led && !prev_led && in_leader) rises++;
      if (bus.irda && bus.ir_led) led_space = 1'b1;
      if (bus.done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("done_kind", 1, e.is_done);
          check("gap_len", run_len, e.len);
          check("led_in_gap", led_space, 0);
        end
        idle = 1'b1;
      end
      prev_irda = bus.irda;
      prev_led  = bus.ir_led;
    end
  end

  task automatic send_frame(input logic [31:0] d);
    bus.data = d;
    bus.send = 1'b1;
    push_frame(d);
    @(posedge clk); #1;
    bus.send = 1'b0;
    bus.data = ~d;
    check("busy_latency", bus.busy, 1);
    check("irda_latency", bus.irda, 0);
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget && bus.done !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    check("done_seen", bus.done, 1);
  endtask

  task automatic wait_falls(input int n, input int budget);
    int k;
    logic p;
    k = 0;
    for (int i = 0; i < budget && k < n; i++) begin
      p = bus.irda;
      @(posedge clk); #1;
      if (p && !bus.irda) k++;
    end
    check("falls_seen", k, n);
  endtask

  int done0;

  initial begin
    bus.send = 1'b1;
    bus.data = 32'hFFFF_FFFF;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_irda", bus.irda, 1);
    check("rst_led", bus.ir_led, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    rst_n = 1'b1;
    bus.send = 1'b0;
    @(posedge clk); #1;
    check("idle_after_rst", bus.busy, 0);

    send_frame(32'hE21D00FF);
    wait_done(2000);
    bus.data = 32'h1234_5678;
    bus.send = 1'b1;
    @(posedge clk); #1;
    bus.send = 1'b0;
    check("send_at_gap_end_ignored", bus.busy, 0);
    send_frame(32'h7F80_5AA5);
    wait_done(2000);
    @(posedge clk); #1;
    check("idle_after_frame", bus.busy, 0);

    send_frame(32'hE21D00FF);
    wait_falls(2, 500);
    repeat (BM + 2) @(posedge clk);
    #1;
    bus.data = 32'h0;
    bus.send = 1'b1;
    @(posedge clk); #1;
    bus.send = 1'b0;
    check("busy_send_ignored", bus.busy, 1);
    done0 = done_cnt;
    wait_done(2000);
    repeat (60) @(posedge clk);
    #1;
    check("single_done", done_cnt - done0, 1);
    check("no_second_frame_busy", bus.busy, 0);
    check("no_second_frame_irda", bus.irda, 1);

    send_frame(32'h7F80_5AA5);
    wait_falls(18, 1500);
    repeat (2) @(posedge clk);
    #1;
    check("mid_mark_irda", bus.irda, 0);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_irda", bus.irda, 1);
    check("abort_led", bus.ir_led, 0);
    check("abort_busy", bus.busy, 0);
    send_frame(32'hE21D00FF);
    wait_done(2000);
    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
